imm_gen_pipe: RTL and testbench

//  Registered, flow-controlled immediate generator for the decode stage, and the

---
 rtl/imm_gen_pipe_if.sv | 32 +++
 rtl/imm_gen_pipe.sv | 132 +++++++++++++
 tb/tb_imm_gen_pipe.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/imm_gen_pipe_if.sv
// Purpose : request/response bundle for the registered immediate generator.
// Latency : n/a (wiring only).
// Backpr. : in_valid/in_ready on the request side, out_valid/out_ready on the result side.
// Ports   : master = requester/consumer side (drives request + out_ready),
//           slave  = generator side (drives in_ready + result + illegal_count).
interface imm_gen_pipe_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5,
  parameter int CNT_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       instr;
  logic [2:0]        imm_src;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   imm;
  logic [TAG_W-1:0]  out_tag;
  logic              illegal;
  logic [CNT_W-1:0]  illegal_count;

  modport master (
    output in_valid, instr, imm_src, in_tag, out_ready,
    input  in_ready, out_valid, imm, out_tag, illegal, illegal_count
  );

  modport slave (
    input  in_valid, instr, imm_src, in_tag, out_ready,
    output in_ready, out_valid, imm, out_tag, illegal, illegal_count
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// Purpose : registered immediate generator (I/S/B/U/J/CSR-zimm/shamt) with tag passthrough.
// Latency : 1 cycle from accept to out_valid when the output register is empty or draining.
// Backpr. : 2-entry skid (main + skid); in_ready is registered and equals !skid_valid.
// Ports   : clk, rst (sync, active-high); bus = imm_gen_pipe_if.slave carrying the
//           request handshake {instr, imm_src, in_tag}, the result handshake
//           {imm, out_tag, illegal} and the saturating illegal_count.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5,
  parameter int CNT_W = 8
) (
  input  logic          clk,
  input  logic          rst,
  imm_gen_pipe_if.slave bus
);

  generate
    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $error("imm_gen_pipe: XLEN must be 32 or 64");
    end
  endgenerate

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tag;
    logic             illegal;
  } res_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  res_t             new_res;
  res_t             main_q,  main_d;
  res_t             skid_q,  skid_d;
  logic             main_vld_q, main_vld_d;
  logic             skid_vld_q, skid_vld_d;
  logic             in_ready_q, in_ready_d;
  logic [CNT_W-1:0] illegal_count_q, illegal_count_d;

  logic accept;
  logic drain;

  // opcode bits never feed any immediate format
  logic unused_opcode;
  assign unused_opcode = ^bus.instr[6:0];

  assign accept = bus.in_valid && in_ready_q;
  assign drain  = main_vld_q && bus.out_ready;

  // Format decode. Sign fill widths are chosen so the top field bit is instr[31],
  // which keeps every replication count >= 1 for both XLEN values.
  always_comb begin
    new_res         = '0;
    new_res.tag     = bus.in_tag;
    new_res.illegal = 1'b0;
    unique case (bus.imm_src)
      3'b000: new_res.imm = {{(XLEN-12){bus.instr[31]}}, bus.instr[31:20]};
      3'b001: new_res.imm = {{(XLEN-12){bus.instr[31]}}, bus.instr[31:25], bus.instr[11:7]};
      3'b010: new_res.imm = {{(XLEN-12){bus.instr[31]}}, bus.instr[7], bus.instr[30:25],
                             bus.instr[11:8], 1'b0};
      3'b011: new_res.imm = {{(XLEN-31){bus.instr[31]}}, bus.instr[30:12], 12'b0};
      3'b100: new_res.imm = {{(XLEN-20){bus.instr[31]}}, bus.instr[19:12], bus.instr[20],
                             bus.instr[30:21], 1'b0};
      3'b101: new_res.imm = {{(XLEN-5){1'b0}}, bus.instr[19:15]};
      3'b110: new_res.imm = (XLEN == 64) ? {{(XLEN-6){1'b0}}, bus.instr[25:20]}
                                         : {{(XLEN-5){1'b0}}, bus.instr[24:20]};
      default: begin
        new_res.imm     = '0;
        new_res.illegal = 1'b1;
      end
    endcase
  end

  // Buffer control. An accept only happens with the skid empty (in_ready_q mirrors
  // !skid_vld_q), so the skid never has to shift and accept in the same cycle.
  always_comb begin
    main_d          = main_q;
    main_vld_d      = main_vld_q;
    skid_d          = skid_q;
    skid_vld_d      = skid_vld_q;
    illegal_count_d = illegal_count_q;

    if (drain) begin
      if (skid_vld_q) begin
        main_d     = skid_q;
        skid_vld_d = 1'b0;
      end else begin
        main_vld_d = 1'b0;
      end
    end

    if (accept) begin
      if (!main_vld_q || drain) begin
        main_d     = new_res;
        main_vld_d = 1'b1;
      end else begin
        skid_d     = new_res;
        skid_vld_d = 1'b1;
      end
      if (new_res.illegal && (illegal_count_q != CNT_MAX)) begin
        illegal_count_d = illegal_count_q + 1'b1;
      end
    end

    in_ready_d = !skid_vld_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_q          <= '0;
      main_vld_q      <= 1'b0;
      skid_q          <= '0;
      skid_vld_q      <= 1'b0;
      in_ready_q      <= 1'b0;
      illegal_count_q <= '0;
    end else begin
      main_q          <= main_d;
      main_vld_q      <= main_vld_d;
      skid_q          <= skid_d;
      skid_vld_q      <= skid_vld_d;
      in_ready_q      <= in_ready_d;
      illegal_count_q <= illegal_count_d;
    end
  end

  assign bus.in_ready      = in_ready_q;
  assign bus.out_valid     = main_vld_q;
  assign bus.imm           = main_q.imm;
  assign bus.out_tag       = main_q.tag;
  assign bus.illegal       = main_q.illegal;
  assign bus.illegal_count = illegal_count_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Purpose : random + directed bench for imm_gen_pipe at XLEN=32 and XLEN=64 side by side.
// Latency : both instances see identical stimulus; results come from a queue model.
// Backpr. : out_ready is randomised; the model tracks occupancy to predict in_ready.
module tb_imm_gen_pipe;

  logic clk;
  logic rst;

  imm_gen_pipe_if #(.XLEN(32), .TAG_W(5), .CNT_W(8)) b32 ();
  imm_gen_pipe_if #(.XLEN(64), .TAG_W(5), .CNT_W(8)) b64 ();

  assign b64.in_valid  = b32.in_valid;
  assign b64.instr     = b32.instr;
  assign b64.imm_src   = b32.imm_src;
  assign b64.in_tag    = b32.in_tag;
  assign b64.out_ready = b32.out_ready;

  imm_gen_pipe #(.XLEN(32), .TAG_W(5), .CNT_W(8)) u_dut32 (
    .clk (clk), .rst (rst), .bus (b32.slave)
  );
  imm_gen_pipe #(.XLEN(64), .TAG_W(5), .CNT_W(8)) u_dut64 (
    .clk (clk), .rst (rst), .bus (b64.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] i32;
    logic [63:0] i64;
    logic [4:0]  tag;
    logic        ill;
  } exp_t;

  exp_t        q[$];
  int          cnt;
  logic        rst_last;
  int          n_vec;
  int          n_err;
  logic        last_acc;
  logic        last_drn;
  logic [4:0]  last_out_tag;
  int          n_acc;
  int          n_drn;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  function automatic longint sext(input longint val, input int bits);
    longint half;
    half = longint'(1) << (bits - 1);
    return (val >= half) ? val - (half * 2) : val;
  endfunction

  // Immediate value as an integer, then wrapped to the output width.
  function automatic logic [63:0] ref_imm(input logic [31:0] ins, input logic [2:0] src,
                                          input int xlen);
    longint v;
    case (src)
      3'd0: v = sext(64'(ins[31:20]), 12);
      3'd1: v = sext(64'({ins[31:25], ins[11:7]}), 12);
      3'd2: v = sext(64'({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}), 13);
      3'd3: v = sext(64'({ins[31:12], 12'b0}), 32);
      3'd4: v = sext(64'({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}), 21);
      3'd5: v = 64'(ins[19:15]);
      3'd6: v = (xlen == 64) ? 64'(ins[25:20]) : 64'(ins[24:20]);
      default: v = 0;
    endcase
    if (xlen == 32) v = v & 64'h0000_0000_FFFF_FFFF;
    return 64'(v);
  endfunction

  // One clock: drive, check at negedge against the model, update model at posedge.
  task automatic cyc(input logic iv, input logic [31:0] ins, input logic [2:0] src,
                     input logic [4:0] tg, input logic ordy, input logic r);
    exp_t e;
    logic acc;
    logic drn;
    logic rdy;
    b32.in_valid  = iv;
    b32.instr     = ins;
    b32.imm_src   = src;
    b32.in_tag    = tg;
    b32.out_ready = ordy;
    rst           = r;
    @(negedge clk);
    rdy = !rst_last && (q.size() < 2);
    chk("in_ready32", 64'(b32.in_ready), 64'(rdy));
    chk("in_ready64", 64'(b64.in_ready), 64'(rdy));
    chk("out_valid32", 64'(b32.out_valid), 64'(q.size() > 0));
    chk("out_valid64", 64'(b64.out_valid), 64'(q.size() > 0));
    if (q.size() > 0) begin
      chk("imm32", 64'(b32.imm), q[0].i32);
      chk("imm64", b64.imm, q[0].i64);
      chk("out_tag32", 64'(b32.out_tag), 64'(q[0].tag));
      chk("out_tag64", 64'(b64.out_tag), 64'(q[0].tag));
      chk("illegal32", 64'(b32.illegal), 64'(q[0].ill));
      chk("illegal64", 64'(b64.illegal), 64'(q[0].ill));
    end
    chk("ill_cnt32", 64'(b32.illegal_count), 64'(cnt));
    chk("ill_cnt64", 64'(b64.illegal_count), 64'(cnt));
    acc = iv && rdy;
    drn = (q.size() > 0) && ordy;
    if (drn) last_out_tag = b32.out_tag;
    @(posedge clk);
    if (r) begin
      q.delete();
      cnt      = 0;
      rst_last = 1'b1;
    end else begin
      rst_last = 1'b0;
      if (drn) void'(q.pop_front());
      if (acc) begin
        e.i32 = ref_imm(ins, src, 32);
        e.i64 = ref_imm(ins, src, 64);
        e.tag = tg;
        e.ill = (src == 3'd7);
        q.push_back(e);
        if (src == 3'd7 && cnt < 255) cnt++;
      end
    end
    last_acc = acc && !r;
    last_drn = drn && !r;
    if (last_acc) n_acc++;
    if (last_drn) n_drn++;
    #1;
  endtask

  initial begin
    n_vec = 0; n_err = 0; cnt = 0; n_acc = 0; n_drn = 0;
    last_acc = 1'b0; last_drn = 1'b0; last_out_tag = '0;
    rst = 1'b1;
    b32.in_valid = 1'b0; b32.instr = '0; b32.imm_src = '0; b32.in_tag = '0;
    b32.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_last = 1'b1;

    // reset state
    chk("rst_out_valid", 64'(b32.out_valid), 64'd0);
    chk("rst_in_ready", 64'(b32.in_ready), 64'd0);
    chk("rst_imm32", 64'(b32.imm), 64'd0);
    chk("rst_imm64", b64.imm, 64'd0);
    chk("rst_tag", 64'(b32.out_tag), 64'd0);
    chk("rst_illegal", 64'(b32.illegal), 64'd0);
    chk("rst_cnt", 64'(b32.illegal_count), 64'd0);

    cyc(1'b0, 32'h0, 3'd0, 5'd0, 1'b1, 1'b0);

    // addi -1, I-type
    cyc(1'b1, 32'hFFF00093, 3'd0, 5'd4, 1'b1, 1'b0);
    chk("t1_imm32", 64'(b32.imm), 64'h0000_0000_FFFF_FFFF);
    chk("t1_illegal", 64'(b32.illegal), 64'd0);
    chk("t1_valid", 64'(b32.out_valid), 64'd1);

    // beq -4 and lui 0x80000 on XLEN=64
    cyc(1'b1, 32'hFE000EE3, 3'd2, 5'd5, 1'b1, 1'b0);
    chk("t2_b64", b64.imm, 64'hFFFF_FFFF_FFFF_FFFC);
    cyc(1'b1, 32'h800000B7, 3'd3, 5'd6, 1'b1, 1'b0);
    chk("t2_u64", b64.imm, 64'hFFFF_FFFF_8000_0000);
    chk("t2_u32", 64'(b32.imm), 64'h0000_0000_8000_0000);
    cyc(1'b0, 32'h0, 3'd0, 5'd0, 1'b1, 1'b0);

    // back-pressure: three requests into a stalled output
    n_acc = 0;
    cyc(1'b1, $urandom(), 3'd0, 5'd1, 1'b0, 1'b0);
    cyc(1'b1, $urandom(), 3'd1, 5'd2, 1'b0, 1'b0);
    cyc(1'b1, 32'h1234_5678, 3'd4, 5'd3, 1'b0, 1'b0);
    chk("t3_acc2", 64'(n_acc), 64'd2);
    chk("t3_rdy_low", 64'(b32.in_ready), 64'd0);
    cyc(1'b1, 32'h1234_5678, 3'd4, 5'd3, 1'b1, 1'b0);
    chk("t3_out1", 64'(last_out_tag), 64'd1);
    chk("t3_no_acc", 64'(last_acc), 64'd0);
    cyc(1'b1, 32'h1234_5678, 3'd4, 5'd3, 1'b1, 1'b0);
    chk("t3_out2", 64'(last_out_tag), 64'd2);
    chk("t3_acc3", 64'(last_acc), 64'd1);
    cyc(1'b0, 32'h0, 3'd0, 5'd0, 1'b1, 1'b0);
    chk("t3_out3", 64'(last_out_tag), 64'd3);

    // full throughput
    n_acc = 0; n_drn = 0;
    for (int i = 0; i < 100; i++) begin
      cyc(1'b1, $urandom(), 3'($urandom_range(0, 6)), 5'($urandom_range(0, 31)), 1'b1, 1'b0);
    end
    cyc(1'b0, 32'h0, 3'd0, 5'd0, 1'b1, 1'b0);
    chk("t4_acc100", 64'(n_acc), 64'd100);
    chk("t4_drn100", 64'(n_drn), 64'd100);

    // illegal format saturation
    for (int i = 0; i < 300; i++) begin
      cyc(1'b1, $urandom(), 3'd7, 5'($urandom_range(0, 31)), 1'b1, 1'b0);
    end
    chk("t5_imm0", b64.imm, 64'd0);
    chk("t5_illegal", 64'(b32.illegal), 64'd1);
    chk("t5_cnt255", 64'(b32.illegal_count), 64'd255);
    cyc(1'b0, 32'h0, 3'd0, 5'd0, 1'b1, 1'b0);

    // reset with both buffers full
    cyc(1'b1, $urandom(), 3'd0, 5'd9, 1'b0, 1'b0);
    cyc(1'b1, $urandom(), 3'd7, 5'd10, 1'b0, 1'b0);
    cyc(1'b1, $urandom(), 3'd1, 5'd11, 1'b0, 1'b1);
    chk("t6_out_valid", 64'(b32.out_valid), 64'd0);
    chk("t6_cnt0", 64'(b32.illegal_count), 64'd0);
    chk("t6_rdy_low", 64'(b32.in_ready), 64'd0);
    cyc(1'b0, 32'h0, 3'd0, 5'd0, 1'b1, 1'b0);
    chk("t6_rdy_high", 64'(b32.in_ready), 64'd1);

    // random traffic with occasional reset
    for (int i = 0; i < 3000; i++) begin
      cyc(1'($urandom_range(0, 9) < 7), $urandom(), 3'($urandom_range(0, 7)),
          5'($urandom_range(0, 31)), 1'($urandom_range(0, 9) < 6),
          1'($urandom_range(0, 199) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
